// File: rtl/timestep_controller.sv
// timestep_controller: decodes 10-bit instructions into per-timestep datapath enables; optional ADDI opcode under `IMM_ADD_EN.
// Latency: EXEC accept (T0) to DONE is 2 cycles for LOAD/MOV/illegal, 4 cycles for ALU ops; enables/CLR are combinational.
// Backpressure: EXEC is ignored while BUSY or when TS!=0; a new instruction may be accepted in the DONE cycle.
module timestep_controller #(
  parameter int NREG   = 4,
  parameter int RSEL_W = 2
) (
  input  logic            CLKb,
  input  logic            CLRb,
  input  logic            EXEC,
  input  logic [9:0]      INSTR,
  input  logic [1:0]      TS,
  output logic            CLR,
  output logic            IR_LD,
  output logic [NREG-1:0] RIN,
  output logic [NREG-1:0] ROUT,
  output logic            EXT_OUT,
  output logic            ACC_LD,
  output logic            G_LD,
  output logic            G_OUT,
  output logic [2:0]      ALU_OP,
  output logic            BUSY,
  output logic            DONE,
  output logic            ILLEGAL,
  output logic            TS_ERR
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [3:0] OP_LOAD = 4'd0;
  localparam logic [3:0] OP_MOV  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_NOT  = 4'd7;
  localparam logic [3:0] OP_ADDI = 4'd8;

  state_t     state, state_nxt;
  logic [9:2] ir, ir_nxt;
  logic [1:0] exp_ts, exp_nxt;
  logic       done_q, done_nxt;
  logic       ill_q, ill_nxt;
  logic       err_q, err_nxt;

  // The two low instruction bits are reserved and never decoded.
  logic unused_rsvd;
  assign unused_rsvd = ^INSTR[1:0];

  logic [3:0]        op;
  logic [RSEL_W-1:0] rx, ry;
  assign op = ir[9:6];
  assign rx = ir[4 +: RSEL_W];
  assign ry = ir[2 +: RSEL_W];

  function automatic logic [NREG-1:0] sel(input logic [RSEL_W-1:0] idx);
    sel      = '0;
    sel[idx] = 1'b1;
  endfunction

  logic            is_two_op, is_addi, is_3step;
  logic [NREG-1:0] d_rin, d_rout;
  logic            d_ext, d_acc, d_gld, d_gout, d_last, d_ill;
  logic [2:0]      d_alu;

  // Enables for the current timestep, assuming TS matches the expected step.
  always_comb begin
    d_rin  = '0;
    d_rout = '0;
    d_ext  = 1'b0;
    d_acc  = 1'b0;
    d_gld  = 1'b0;
    d_gout = 1'b0;
    d_alu  = 3'b000;
    d_last = 1'b0;
    d_ill  = 1'b0;
    is_two_op = (op >= OP_ADD) && (op <= OP_XOR);
`ifdef IMM_ADD_EN
    is_addi = (op == OP_ADDI);
`else
    is_addi = 1'b0;
`endif
    is_3step = is_two_op || (op == OP_NOT) || is_addi;
    if (op == OP_LOAD) begin
      d_ext  = 1'b1;
      d_rin  = sel(rx);
      d_last = 1'b1;
    end else if (op == OP_MOV) begin
      d_rout = sel(ry);
      d_rin  = sel(rx);
      d_last = 1'b1;
    end else if (is_3step) begin
      case (exp_ts)
        2'd1: begin
          d_rout = sel(rx);
          d_acc  = 1'b1;
        end
        2'd2: begin
          d_gld = 1'b1;
          if (is_two_op) begin
            d_rout = sel(ry);
            d_alu  = 3'(op - OP_ADD);
          end else if (is_addi) begin
            d_ext = 1'b1;
          end else begin
            d_alu = 3'b101;
          end
        end
        2'd3: begin
          d_gout = 1'b1;
          d_rin  = sel(rx);
          d_last = 1'b1;
        end
        default: ;
      endcase
    end else begin
      d_last = 1'b1;
      d_ill  = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    ir_nxt    = ir;
    exp_nxt   = exp_ts;
    done_nxt  = 1'b0;
    ill_nxt   = 1'b0;
    err_nxt   = err_q;
    CLR       = 1'b1;
    IR_LD     = 1'b0;
    RIN       = '0;
    ROUT      = '0;
    EXT_OUT   = 1'b0;
    ACC_LD    = 1'b0;
    G_LD      = 1'b0;
    G_OUT     = 1'b0;
    ALU_OP    = 3'b000;
    if (CLRb) begin
      case (state)
        S_IDLE: begin
          if (EXEC && (TS == 2'd0)) begin
            IR_LD     = 1'b1;
            CLR       = 1'b0;
            ir_nxt    = INSTR[9:2];
            exp_nxt   = 2'd1;
            state_nxt = S_RUN;
          end
        end
        S_RUN: begin
          // A counter that disagrees with our step count aborts with no side effects.
          if (TS != exp_ts) begin
            err_nxt   = 1'b1;
            exp_nxt   = 2'd0;
            state_nxt = S_IDLE;
          end else begin
            RIN     = d_rin;
            ROUT    = d_rout;
            EXT_OUT = d_ext;
            ACC_LD  = d_acc;
            G_LD    = d_gld;
            G_OUT   = d_gout;
            ALU_OP  = d_alu;
            if (d_last) begin
              done_nxt  = 1'b1;
              ill_nxt   = d_ill;
              exp_nxt   = 2'd0;
              state_nxt = S_IDLE;
            end else begin
              CLR     = 1'b0;
              exp_nxt = exp_ts + 2'd1;
            end
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(negedge CLKb) begin
    if (!CLRb) begin
      state  <= S_IDLE;
      ir     <= '0;
      exp_ts <= 2'd0;
      done_q <= 1'b0;
      ill_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      ir     <= ir_nxt;
      exp_ts <= exp_nxt;
      done_q <= done_nxt;
      ill_q  <= ill_nxt;
      err_q  <= err_nxt;
    end
  end

  assign BUSY    = (state == S_RUN);
  assign DONE    = done_q;
  assign ILLEGAL = ill_q;
  assign TS_ERR  = err_q;

endmodule

// File: tb/tb_timestep_controller.sv
// Bench for timestep_controller: models the 2-bit counter and checks every cycle against an instruction-level model.
module tb_timestep_controller;

  logic       CLKb = 1'b1;
  logic       CLRb, EXEC;
  logic [9:0] INSTR;
  logic [1:0] TS;
  logic       CLR, IR_LD, EXT_OUT, ACC_LD, G_LD, G_OUT;
  logic [3:0] RIN, ROUT;
  logic [2:0] ALU_OP;
  logic       BUSY, DONE, ILLEGAL, TS_ERR;

  logic [1:0] cnt = 2'd0, cnt_nxt = 2'd0;
  logic       ts_force = 1'b0;
  logic [1:0] ts_val = 2'd0;
  assign TS = ts_force ? ts_val : cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_n = 0;

  always #5 CLKb = ~CLKb;

  timestep_controller #(.NREG(4), .RSEL_W(2)) dut (
    .CLKb(CLKb), .CLRb(CLRb), .EXEC(EXEC), .INSTR(INSTR), .TS(TS),
    .CLR(CLR), .IR_LD(IR_LD), .RIN(RIN), .ROUT(ROUT), .EXT_OUT(EXT_OUT),
    .ACC_LD(ACC_LD), .G_LD(G_LD), .G_OUT(G_OUT), .ALU_OP(ALU_OP),
    .BUSY(BUSY), .DONE(DONE), .ILLEGAL(ILLEGAL), .TS_ERR(TS_ERR)
  );

  typedef struct packed {
    logic       clr, ir_ld;
    logic [3:0] rin, rout;
    logic       ext, acc, gld, gout;
    logic [2:0] alu;
    logic       busy, done, ill, err;
  } obs_t;

  // Instruction-level model: current instruction, which timestep it is on, and status flags.
  bit         m_busy, m_done, m_ill, m_err;
  logic [3:0] m_op = 4'd0;
  logic [1:0] m_rx = 2'd0, m_ry = 2'd0, m_step = 2'd0;

  function automatic bit is_legal(input logic [3:0] op);
`ifdef IMM_ADD_EN
    return (op <= 4'd8);
`else
    return (op <= 4'd7);
`endif
  endfunction

  function automatic logic [1:0] instr_len(input logic [3:0] op);
    if (is_legal(op) && op >= 4'd2) return 2'd3;
    return 2'd1;
  endfunction

  function automatic logic [2:0] alu_code(input logic [3:0] op);
    case (op)
      4'd3: return 3'd1;   // SUB
      4'd4: return 3'd2;   // AND
      4'd5: return 3'd3;   // OR
      4'd6: return 3'd4;   // XOR
      4'd7: return 3'd5;   // NOT
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] i);
    logic [3:0] one = 4'b0001;
    return one << i;
  endfunction

  function automatic obs_t expect_obs(input logic clrb, input logic exec, input logic [1:0] ts);
    obs_t o = '0;
    o.busy = m_busy; o.done = m_done; o.ill = m_ill; o.err = m_err;
    o.clr  = 1'b1;
    if (!clrb) return o;
    if (!m_busy) begin
      if (exec && ts == 2'd0) begin o.ir_ld = 1'b1; o.clr = 1'b0; end
      return o;
    end
    if (ts != m_step) return o;
    o.clr = (m_step == instr_len(m_op));
    if (!is_legal(m_op)) return o;
    if (instr_len(m_op) == 2'd1) begin
      o.rin = onehot(m_rx);
      if (m_op == 4'd0) o.ext = 1'b1;
      else              o.rout = onehot(m_ry);
    end else begin
      case (m_step)
        2'd1: begin o.rout = onehot(m_rx); o.acc = 1'b1; end
        2'd2: begin
          o.gld = 1'b1;
          o.alu = alu_code(m_op);
          if (m_op == 4'd8)      o.ext  = 1'b1;
          else if (m_op != 4'd7) o.rout = onehot(m_ry);
        end
        default: begin o.gout = 1'b1; o.rin = onehot(m_rx); end
      endcase
    end
    return o;
  endfunction

  task automatic model_step(input logic clrb, input logic exec, input logic [9:0] instr, input logic [1:0] ts);
    if (!clrb) begin
      m_busy = 0; m_done = 0; m_ill = 0; m_err = 0; m_step = 2'd0;
    end else begin
      m_done = 0; m_ill = 0;
      if (!m_busy) begin
        if (exec && ts == 2'd0) begin
          m_busy = 1; m_op = instr[9:6]; m_rx = instr[5:4]; m_ry = instr[3:2]; m_step = 2'd1;
        end
      end else if (ts != m_step) begin
        m_err = 1; m_busy = 0; m_step = 2'd0;
      end else if (m_step == instr_len(m_op)) begin
        m_busy = 0; m_done = 1; m_ill = !is_legal(m_op); m_step = 2'd0;
      end else begin
        m_step = m_step + 2'd1;
      end
    end
  endtask

  // Mid-cycle compare; inputs only change just after the falling (active) edge.
  always @(posedge CLKb) begin : cmp
    obs_t e, a;
    e = expect_obs(CLRb, EXEC, TS);
    a = {CLR, IR_LD, RIN, ROUT, EXT_OUT, ACC_LD, G_LD, G_OUT, ALU_OP, BUSY, DONE, ILLEGAL, TS_ERR};
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL model cycle %0d: got %h expected %h (TS=%0d)", cyc_n, a, e, TS);
    end
    model_step(CLRb, EXEC, INSTR, TS);
    cnt_nxt = CLR ? 2'd0 : cnt + 2'd1;
    cyc_n++;
  end

  always @(negedge CLKb) cnt <= cnt_nxt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Apply one cycle of inputs just after the falling edge, then move to the mid-cycle sample point.
  task automatic drive(input logic clrb, input logic exec, input logic [9:0] instr,
                       input logic tsf = 1'b0, input logic [1:0] tsv = 2'd0);
    @(negedge CLKb); #1;
    CLRb = clrb; EXEC = exec; INSTR = instr; ts_force = tsf; ts_val = tsv;
    @(posedge CLKb); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    CLRb = 1'b0; EXEC = 1'b0; INSTR = '0;
    drive(0, 0, 0); chk("rst_clr", CLR, 1); chk("rst_busy", BUSY, 0);
    drive(0, 1, 0); chk("rst_err", TS_ERR, 0); chk("rst_irld", IR_LD, 0);
    drive(1, 0, 0); chk("idle_clr", CLR, 1); chk("idle_ts", TS, 0);

    // LOAD R2
    drive(1, 1, 10'b0000_10_00_00); chk("load_irld", IR_LD, 1); chk("load_clr0", CLR, 0);
    drive(1, 0, 0); chk("load_ts", TS, 1); chk("load_ext", EXT_OUT, 1);
    chk("load_rin", RIN, 4'b0100); chk("load_clr", CLR, 1);
    drive(1, 0, 0); chk("load_done", DONE, 1); chk("load_busy", BUSY, 0); chk("load_ts0", TS, 0);

    // ADD R1,R2
    drive(1, 1, 10'b0010_01_10_00); chk("add_irld", IR_LD, 1);
    drive(1, 0, 0); chk("add_t1_rout", ROUT, 4'b0010); chk("add_t1_acc", ACC_LD, 1);
    drive(1, 0, 0); chk("add_t2_rout", ROUT, 4'b0100); chk("add_t2_gld", G_LD, 1); chk("add_t2_alu", ALU_OP, 0);
    drive(1, 0, 0); chk("add_t3_gout", G_OUT, 1); chk("add_t3_rin", RIN, 4'b0010); chk("add_t3_clr", CLR, 1);
    drive(1, 0, 0); chk("add_done", DONE, 1); chk("add_ill", ILLEGAL, 0);

    // MOV R3,R0 then NOT R3 back to back
    drive(1, 1, 10'b0001_11_00_00); chk("mov_irld", IR_LD, 1);
    drive(1, 1, 10'b0111_11_00_00); chk("mov_rin", RIN, 4'b1000); chk("mov_rout", ROUT, 4'b0001);
    drive(1, 1, 10'b0111_11_00_00); chk("b2b_done", DONE, 1); chk("b2b_irld", IR_LD, 1);
    drive(1, 1, 10'b0111_11_00_00); chk("not_t1_rout", ROUT, 4'b1000); chk("not_t1_irld", IR_LD, 0);
    drive(1, 0, 0); chk("not_t2_alu", ALU_OP, 3'b101); chk("not_t2_rout", ROUT, 0); chk("not_t2_gld", G_LD, 1);
    drive(1, 0, 0); chk("not_t3_rin", RIN, 4'b1000);
    drive(1, 0, 0); chk("not_done", DONE, 1);

    // Undefined opcode 1100
    drive(1, 1, 10'b1100_01_10_00); chk("ill_irld", IR_LD, 1);
    drive(1, 0, 0); chk("ill_t1_en", {RIN, ROUT, EXT_OUT, ACC_LD, G_LD, G_OUT}, 0); chk("ill_t1_clr", CLR, 1);
    drive(1, 0, 0); chk("ill_done", DONE, 1); chk("ill_flag", ILLEGAL, 1);
    drive(1, 0, 0); chk("ill_pulse", ILLEGAL, 0);

    // Opcode 1000
    drive(1, 1, 10'b1000_01_00_00); chk("op8_irld", IR_LD, 1);
`ifdef IMM_ADD_EN
    drive(1, 0, 0); chk("addi_t1_rout", ROUT, 4'b0010); chk("addi_t1_acc", ACC_LD, 1);
    drive(1, 0, 0); chk("addi_t2_ext", EXT_OUT, 1); chk("addi_t2_gld", G_LD, 1);
    drive(1, 0, 0); chk("addi_t3_rin", RIN, 4'b0010);
    drive(1, 0, 0); chk("addi_done", DONE, 1); chk("addi_ill", ILLEGAL, 0);
`else
    drive(1, 0, 0); chk("op8_t1_en", {RIN, ROUT, EXT_OUT, ACC_LD, G_LD, G_OUT}, 0);
    drive(1, 0, 0); chk("op8_done", DONE, 1); chk("op8_ill", ILLEGAL, 1);
`endif

    // Desync during SUB T1
    drive(1, 1, 10'b0011_00_01_00); chk("sub_irld", IR_LD, 1);
    drive(1, 0, 0, 1'b1, 2'd3); chk("desync_en", {ROUT, ACC_LD}, 0); chk("desync_clr", CLR, 1);
    drive(1, 0, 0); chk("desync_err", TS_ERR, 1); chk("desync_busy", BUSY, 0); chk("desync_done", DONE, 0);
    drive(1, 1, 10'b0000_00_00_00);
    drive(1, 0, 0);
    drive(1, 0, 0); chk("sticky_done", DONE, 1); chk("sticky_err", TS_ERR, 1);

    // Reset at T2 of XOR
    drive(1, 1, 10'b0110_01_10_00); chk("xor_irld", IR_LD, 1);
    drive(1, 0, 0);
    drive(0, 0, 0); chk("xrst_clr", CLR, 1); chk("xrst_en", {ROUT, G_LD}, 0);
    drive(1, 0, 0); chk("xrst_busy", BUSY, 0); chk("xrst_done", DONE, 0); chk("xrst_err", TS_ERR, 0);
    drive(1, 1, 10'b0000_01_00_00); chk("xrst_restart", IR_LD, 1);
    drive(1, 0, 0);
    drive(1, 0, 0); chk("xrst_load_done", DONE, 1);

    // Randomized traffic, biased toward legal opcodes
    for (int i = 0; i < 1500; i++) begin
      logic [3:0] op;
      logic [9:0] ins;
      op  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 8));
      ins = {op, 6'($urandom)};
      drive($urandom_range(0, 59) != 0, $urandom_range(0, 3) != 0, ins,
            $urandom_range(0, 39) == 0, 2'($urandom));
    end
    drive(1, 0, 0);
    drive(1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/timestep_controller.md
Name: timestep_controller

Overview:
- Control sequencer for the 10-bit processor; the consumer end of the 2-bit timestep counter interface.
- Reads the counter's CNT on TS and drives CLR back to it.
- Latches the instruction at T0, decodes it, and emits per-timestep datapath enables.
- Emits DONE/BUSY status, and tracks the expected timestep internally to detect counter desync.

Parameters:
- NREG, 4, number of general registers (width of RIN/ROUT); must equal 2**RSEL_W.
- RSEL_W, 2, register-select field width in the instruction.

Ports:
- CLKb  in  1  active-low clock; all state updates on falling edge.
- CLRb  in  1  synchronous active-low reset, sampled on falling edge of CLKb.
- EXEC  in  1  start request.
- INSTR  in  10  instruction: [9:6] opcode, [5:4] Rx, [3:2] Ry, [1:0] reserved/ignored.
- TS  in  2  timestep count from the counter.
- CLR  out  1  clear to the counter.
- IR_LD  out  1  instruction-register load.
- RIN  out  NREG  one-hot register write enable.
- ROUT  out  NREG  one-hot register bus drive.
- EXT_OUT  out  1  drive external data onto the bus.
- ACC_LD  out  1  load A (ALU operand) register.
- G_LD  out  1  load G (ALU result) register.
- G_OUT  out  1  drive G onto the bus.
- ALU_OP  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT; 000 when unused.
- BUSY  out  1  instruction in progress (registered).
- DONE  out  1  one-cycle completion pulse (registered).
- ILLEGAL  out  1  one-cycle pulse with DONE when the opcode is undefined.
- TS_ERR  out  1  sticky counter-desync flag.

Behaviour:
- Reset (CLRb=0 at a falling edge): BUSY=0, DONE=0, ILLEGAL=0, TS_ERR=0, IR=0, expected TS=0.
  - While CLRb=0: CLR=1 and all enables are 0.
- Outputs:
  - BUSY, DONE, ILLEGAL, TS_ERR, IR and expected TS are registered.
  - The enables and CLR are combinational from (BUSY, IR, TS, EXEC).
- IDLE (BUSY=0):
  - CLR=1 unless EXEC=1 and TS=0.
  - If EXEC=1 and TS=0 (T0): IR_LD=1, CLR=0. At the edge: IR<=INSTR, BUSY<=1, expected<=1.
  - If EXEC=1 and TS!=0: no start, CLR=1, no error.
- Opcodes (Rx/Ry select one-hot RIN/ROUT bits):
  - 0000 LOAD: T1 EXT_OUT, RIN[Rx]; last.
  - 0001 MOV: T1 ROUT[Ry], RIN[Rx]; last.
  - 0010 ADD, 0011 SUB, 0100 AND, 0101 OR, 0110 XOR:
    - T1 ROUT[Rx], ACC_LD.
    - T2 ROUT[Ry], G_LD, ALU_OP.
    - T3 G_OUT, RIN[Rx]; last.
  - 0111 NOT:
    - T1 ROUT[Rx], ACC_LD.
    - T2 G_LD, ALU_OP=101.
    - T3 G_OUT, RIN[Rx]; last.
  - Others: illegal. T1 has no enables; last; ILLEGAL pulses.
- Last timestep:
  - CLR=1.
  - At the edge: BUSY<=0, DONE<=1 for one cycle, expected<=0.
  - Latency EXEC-accept to DONE: 2 cycles for LOAD/MOV/illegal, 4 cycles for ALU ops.
- Non-last timestep: CLR=0; expected increments at the edge.
- EXEC while BUSY: ignored.
  - The next instruction may start in the cycle DONE is high (TS=0 then): back-to-back, no gap.
- Desync: while BUSY, if TS != expected:
  - All enables are forced to 0 and CLR=1 that cycle.
  - At the edge: TS_ERR<=1 (sticky until reset), BUSY<=0, expected<=0, no DONE.
- Reset mid-instruction: aborts immediately to reset values; no DONE; no register writes in that cycle.
- Enable exclusivity:
  - At most one bus driver (ROUT bit, EXT_OUT, G_OUT) is active in any cycle.
  - At most one RIN bit is active.

Optional Feature:
- Macro IMM_ADD_EN.
- Defined: opcode 1000 = ADDI (Rx <= Rx + external data).
  - T1 ROUT[Rx], ACC_LD.
  - T2 EXT_OUT, G_LD, ALU_OP=000.
  - T3 G_OUT, RIN[Rx]; last.
- Undefined: 1000 is illegal like the other undefined codes.

Test Plan:
- Reset, then EXEC=1 with INSTR=0000_10_00_00 at TS=0 → IR_LD=1, CLR=0. Next cycle: TS=1, EXT_OUT=1, RIN=0100, CLR=1. Next cycle: DONE=1, BUSY=0, TS=0.
- ADD R1,R2 (INSTR=0010_01_10_00), counter connected:
  - T1 ROUT=0010, ACC_LD.
  - T2 ROUT=0100, G_LD, ALU_OP=000.
  - T3 G_OUT, RIN=0010, CLR=1.
  - DONE 4 cycles after accept.
- Back-to-back: MOV R3,R0 then NOT R3 with EXEC held high → second IR_LD in the DONE cycle; NOT completes 4 cycles later with ALU_OP=101 at T2.
- Opcode 1100 → T1 all enables 0, DONE=1 and ILLEGAL=1 together for one cycle. Opcode 1000 → same if IMM_ADD_EN undefined; ADDI sequence with EXT_OUT at T2 if defined.
- Force TS=3 during T1 of SUB → enables 0, CLR=1; next cycle TS_ERR=1, BUSY=0, DONE=0; TS_ERR stays 1 through later instructions until CLRb=0.
- CLRb=0 at T2 of XOR → next cycle all registered outputs 0, CLR=1, no DONE; EXEC at TS=0 then starts normally.
